// File: rtl/booth_q_reg.sv
// Q (multiplier) register for the sequential Booth multiplier: W bits plus the q_-1 guard bit,
// with a right-shift step counter. Define BOOTH_Q_RADIX4_EN for radix-4 (two bits per step).
module booth_q_reg #(
  parameter int W  = 8,
  localparam int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    sel,
  input  logic [W-1:0]  in,
  input  logic [1:0]    sr_in,
  input  logic          sl_in,
  output logic [W-1:0]  out,
  output logic          q_1,
  output logic [2:0]    booth,
  output logic          msb_out,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_SHR   = 2'b01;
  localparam logic [1:0] SEL_SHL   = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

`ifdef BOOTH_Q_RADIX4_EN
  localparam logic [CW-1:0] STEPS = CW'(W / 2);
`else
  localparam logic [CW-1:0] STEPS = CW'(W);
`endif

  logic [W-1:0] shr_val;
  logic         shr_q_1;

`ifdef BOOTH_Q_RADIX4_EN
  assign shr_val = {sr_in[1:0], out[W-1:2]};
  assign shr_q_1 = out[1];
  assign booth   = {out[1], out[0], q_1};
`else
  // Radix-2 only consumes one serial bit; the upper one is deliberately dropped.
  logic unused_sr_hi;
  assign unused_sr_hi = sr_in[1];
  assign shr_val = {sr_in[0], out[W-1:1]};
  assign shr_q_1 = out[0];
  assign booth   = {1'b0, out[0], q_1};
`endif

  assign msb_out = out[W-1];
  assign done    = (cnt == STEPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
    end else begin
      case (sel)
        SEL_HOLD: ;
        SEL_SHR: begin
          // Once the step count is reached, further right shifts are no-ops and cnt saturates.
          if (!done) begin
            out <= shr_val;
            q_1 <= shr_q_1;
            cnt <= cnt + 1'b1;
          end
        end
        SEL_SHL: begin
          out <= {out[W-2:0], sl_in};
          q_1 <= 1'b0;
        end
        SEL_LOAD: begin
          out <= in;
          q_1 <= 1'b0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_q_reg.sv
// Directed-vector bench for booth_q_reg (W=8); radix-4 vectors are used when
// BOOTH_Q_RADIX4_EN is defined, radix-2 vectors otherwise.
module tb_booth_q_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic          clk;
  logic          rst;
  logic [1:0]    sel;
  logic [W-1:0]  in;
  logic [1:0]    sr_in;
  logic          sl_in;
  logic [W-1:0]  out;
  logic          q_1;
  logic [2:0]    booth;
  logic          msb_out;
  logic [CW-1:0] cnt;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  booth_q_reg #(.W(W)) dut (
    .clk(clk), .rst(rst), .sel(sel), .in(in), .sr_in(sr_in), .sl_in(sl_in),
    .out(out), .q_1(q_1), .booth(booth), .msb_out(msb_out), .cnt(cnt), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Applies one operation across a single rising edge, then settles #1 past it.
  task automatic apply(input logic [1:0] s, input logic [W-1:0] d, input logic [1:0] sr, input logic sl);
    sel   = s;
    in    = d;
    sr_in = sr;
    sl_in = sl;
    @(posedge clk);
    #1;
    sel = 2'b00;
  endtask

  task automatic check_state(input string tag, input logic [W-1:0] e_out, input logic e_q1,
                             input logic [CW-1:0] e_cnt, input logic e_done);
    check({tag, ".out"},  32'(out),  32'(e_out));
    check({tag, ".q_1"},  32'(q_1),  32'(e_q1));
    check({tag, ".cnt"},  32'(cnt),  32'(e_cnt));
    check({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  initial begin
    rst = 1'b0; sel = 2'b00; in = '0; sr_in = 2'b00; sl_in = 1'b0;
    #2;
    // Async reset between edges, checked before any clock edge occurs.
    rst = 1'b1;
    #1;
    check_state("reset", 8'h00, 1'b0, 4'd0, 1'b0);
    check("reset.booth", 32'(booth), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef BOOTH_Q_RADIX4_EN
    apply(2'b11, 8'hB5, 2'b00, 1'b0);
    check_state("r4_load", 8'hB5, 1'b0, 4'd0, 1'b0);
    apply(2'b01, 8'h00, 2'b11, 1'b0);
    check_state("r4_shr1", 8'hED, 1'b0, 4'd1, 1'b0);
    check("r4_shr1.booth", 32'(booth), 32'b010);
    for (int i = 2; i <= 4; i++) apply(2'b01, 8'h00, 2'b11, 1'b0);
    check_state("r4_shr4", 8'hFF, 1'b1, 4'd4, 1'b1);
    check("r4_shr4.booth", 32'(booth), 32'b111);
    apply(2'b01, 8'h00, 2'b00, 1'b0);
    check_state("r4_shr5", 8'hFF, 1'b1, 4'd4, 1'b1);
    apply(2'b11, 8'h00, 2'b00, 1'b0);
    check_state("r4_reload", 8'h00, 1'b0, 4'd0, 1'b0);
`else
    apply(2'b11, 8'hB5, 2'b00, 1'b0);
    check_state("load", 8'hB5, 1'b0, 4'd0, 1'b0);
    check("load.booth", 32'(booth), 32'b010);
    check("load.msb", 32'(msb_out), 32'h1);

    apply(2'b00, 8'h3C, 2'b11, 1'b1);
    check_state("hold", 8'hB5, 1'b0, 4'd0, 1'b0);

    apply(2'b01, 8'h00, 2'b01, 1'b0);
    check_state("shr1", 8'hDA, 1'b1, 4'd1, 1'b0);
    check("shr1.booth", 32'(booth), 32'b001);
    // sr_in[1] set here must not leak into a radix-2 shift
    apply(2'b01, 8'h00, 2'b11, 1'b0);
    check_state("shr2", 8'hED, 1'b0, 4'd2, 1'b0);
    for (int i = 3; i <= 8; i++) apply(2'b01, 8'h00, 2'b01, 1'b0);
    check_state("shr8", 8'hFF, 1'b1, 4'd8, 1'b1);
    apply(2'b01, 8'h00, 2'b00, 1'b0);
    check_state("shr9", 8'hFF, 1'b1, 4'd8, 1'b1);

    apply(2'b10, 8'h00, 2'b00, 1'b0);
    check_state("shl_done", 8'hFE, 1'b0, 4'd8, 1'b1);

    apply(2'b11, 8'h00, 2'b00, 1'b0);
    check_state("load0", 8'h00, 1'b0, 4'd0, 1'b0);

    apply(2'b11, 8'h81, 2'b00, 1'b0);
    check("shl.msb_before", 32'(msb_out), 32'h1);
    apply(2'b10, 8'h00, 2'b00, 1'b1);
    check_state("shl", 8'h03, 1'b0, 4'd0, 1'b0);
    check("shl.msb_after", 32'(msb_out), 32'h0);

    apply(2'b11, 8'h5A, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) apply(2'b01, 8'h00, 2'b00, 1'b0);
    check_state("mid3", 8'h0B, 1'b0, 4'd3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_state("mid_rst", 8'h00, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    apply(2'b11, 8'h0F, 2'b00, 1'b0);
    check_state("post_rst_load", 8'h0F, 1'b0, 4'd0, 1'b0);
    check("post_rst_load.booth", 32'(booth), 32'b010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_q_reg.md
# booth_q_reg

Parametrised Q (multiplier) register for the sequential Booth multiplier datapath, W bits plus the q_-1 guard bit. It holds, loads, arithmetic-shifts right (taking serial bits from the A register), or shifts left. It also runs an internal step counter that raises `done` after the required number of right shifts. It sits beside the A and M registers and feeds the Booth recode bits to the control unit, replacing the fixed 8-bit Q register.

## Interface
- `W`, default 8: Q width in bits; must be ≥2, and even when `BOOTH_Q_RADIX4_EN` is defined.
- `CW`, derived as $clog2(W)+1 (localparam): counter width.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `sel`, input, 2: operation select. 00 = hold, 01 = shift right, 10 = shift left, 11 = load.
- `in`, input, W: parallel load data.
- `sr_in`, input, 2: serial input from the A register's low bits. Radix-2 uses `sr_in[0]`; radix-4 uses both bits.
- `sl_in`, input, 1: bit inserted at the LSB on a left shift.
- `out`, output, W: register contents.
- `q_1`, output, 1: the q_-1 guard bit.
- `booth`, output, 3: recode bits {out[1], out[0], q_1}. In radix-2 builds, `booth[2]` is tied to 0.
- `msb_out`, output, 1: equals out[W-1], for feeding A on left shifts.
- `cnt`, output, CW: number of right shifts performed since the last load.
- `done`, output, 1: asserted while cnt == STEPS.

## Operation
STEPS = W in radix-2 builds, W/2 in radix-4 builds.

- **sel=00 (hold):** all state unchanged.
- **sel=01 (shift right), when done=0:**
  - Radix-2: out ← {sr_in[0], out[W-1:1]}; q_1 ← out[0]; cnt ← cnt+1.
  - Radix-4: out ← {sr_in[1:0], out[W-1:2]}; q_1 ← out[1]; cnt ← cnt+1.
- **sel=01 (shift right), when done=1:** ignored; all state held, cnt does not wrap.
- **sel=10 (shift left):** out ← {out[W-2:0], sl_in}; q_1 ← 0; cnt unchanged. This is a normalisation helper and is not blocked by done.
- **sel=11 (load):** out ← in; q_1 ← 0; cnt ← 0. Load wins regardless of done, so done deasserts on the next cycle.
- **done:** the combinational compare (cnt == STEPS) on registered cnt; no extra state.
- **Unknown/X on sel:** out of scope; the bench keeps sel defined.

## Timing
- **Reset:** out=0, q_1=0, cnt=0, so done=0 and booth=0.
- **Reset timing:** takes effect immediately on rst rising, with no clock edge needed, and holds while rst=1. Reset mid-operation aborts the sequence; the first edge after deassertion obeys sel.
- **Latency:** every operation has one-cycle latency; results are visible after the capturing edge.
- **Outputs:** booth, msb_out and done are combinational functions of registered state only; there are no input-to-output combinational paths.
- **Step timing:** done rises in the cycle after the STEPS-th accepted right shift and stays high until load or reset.
- **Control protocol:** the controller issues exactly STEPS right shifts after load. Extra shift-right requests while done=1 are harmless no-ops.

## Configuration
- **`BOOTH_Q_RADIX4_EN` defined:** radix-4 (modified Booth) mode.
  - Right shift moves two bits per step using sr_in[1:0].
  - q_1 takes out[1].
  - STEPS = W/2.
  - booth[2] carries out[1].
- **`BOOTH_Q_RADIX4_EN` undefined:** radix-2 behaviour.
  - sr_in[1] is ignored.
  - STEPS = W.
  - booth[2] = 0.
- Ports are identical in both builds.

## Test plan
All scenarios use W=8.

1. **Reset:** assert rst asynchronously between edges → out=0x00, q_1=0, cnt=0, done=0 immediately, before any clock edge.
2. **Load (radix-2):** sel=11, in=0xB5 → out=0xB5, q_1=0, cnt=0, booth=3'b010, msb_out=1.
3. **Right shifts (radix-2):** after loading 0xB5, apply sel=01 with sr_in=2'b01.
   - After 1st shift → out=0xDA, q_1=1, cnt=1.
   - After 8th shift → out=0xFF, q_1=1, cnt=8, done=1.
   - 9th shift → no change.
   - Load 0x00 → cnt=0, done=0.
4. **Left shift:** load 0x81, then sel=10 with sl_in=1 → out=0x03, q_1=0, cnt unchanged at 0. msb_out was 1 before the edge.
5. **Reset mid-operation:** after 3 right shifts (cnt=3), pulse rst → immediate zeroing. Then load 0x0F → out=0x0F, cnt=0, done=0.
6. **Radix-4 (`BOOTH_Q_RADIX4_EN` defined):** load 0xB5; shift right with sr_in=2'b11.
   - After 1st shift → out=0xED, q_1=0, booth=3'b010, cnt=1.
   - After 4th shift → done=1.
   - 5th shift ignored.
